vga_tmds_encoder: RTL and testbench

Three-channel DVI/TMDS encoder sitting directly downstream of the `vga` timing/pixel generator. It consumes `vga_r/g/b`, `vga_hsync`, `vga_vsync` and `vga_blank` in the pixel clock domain. Each 8-bit colour, or the 2-bit control pair during blanking, becomes a 10-bit DC-balanced TMDS symbol per channel. The symbols feed the serializer/DDR output stage, bit 0 first.

---
 rtl/tmds_pkg.sv | 17 +
 rtl/vga_tmds_encoder_if.sv | 16 +
 rtl/tmds_channel_encoder.sv | 67 ++++++
 rtl/vga_tmds_encoder.sv | 25 ++
 tb/tb_vga_tmds_encoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS constants, control tokens and popcount helper.
package tmds_pkg;
  localparam int TMDS_SYM_W = 10;
  localparam int TMDS_CNT_W = 5;
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 += {3'b000, v[i]};
  endfunction
  function automatic logic [9:0] tmds_token(input logic [1:0] c);
    return c == 2'b00 ? TMDS_CTRL_00 : c == 2'b01 ? TMDS_CTRL_01 :
           c == 2'b10 ? TMDS_CTRL_10 : TMDS_CTRL_11;
  endfunction
endpackage

// File: rtl/vga_tmds_encoder_if.sv
// vga_tmds_encoder_if: pixel-side inputs and TMDS symbol outputs of the encoder.
interface vga_tmds_encoder_if;
  logic       clk_pixel_ena;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_blank;
  logic [9:0] tmds_r, tmds_g, tmds_b;
  logic       tmds_blank;
  modport master (
    output clk_pixel_ena, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank,
    input  tmds_r, tmds_g, tmds_b, tmds_blank
  );
  modport slave (
    input  clk_pixel_ena, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank,
    output tmds_r, tmds_g, tmds_b, tmds_blank
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane, transition minimisation then DC balance.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter bit C_PIPE_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            data,
  input  logic [1:0]            c,
  input  logic                  blank,
  output logic [TMDS_SYM_W-1:0] sym,
  output logic                  blank_o
);
  function automatic logic [7:0] chain(input logic [7:0] d, input logic use_xnor);
    chain[0] = d[0];
    for (int i = 1; i < 8; i++) chain[i] = use_xnor ? ~(chain[i-1] ^ d[i]) : chain[i-1] ^ d[i];
  endfunction
  logic [3:0]                   n1d, n1;
  logic                         use_xnor, case_a, case_b, q8;
  logic [7:0]                   qm;
  logic [8:0]                   qm_q;
  logic                         blank_q, blank_o_q;
  logic [1:0]                   c_q;
  logic signed [TMDS_CNT_W-1:0] diff, cnt_d, cnt_q;
  logic [TMDS_SYM_W-1:0]        sym_d, sym_q;
  always_comb begin
    n1d      = popcount8(data);
    use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !data[0]);
  end
  // diff is n1-n0 of q_m[7:0], i.e. 2*n1-8, kept in the 5-bit disparity domain
  always_comb begin
    qm     = qm_q[7:0];
    q8     = qm_q[8];
    n1     = popcount8(qm);
    diff   = $signed({n1, 1'b0}) - 5'sd8;
    case_a = cnt_q == 5'sd0 || diff == 5'sd0;
    case_b = (cnt_q > 5'sd0 && diff > 5'sd0) || (cnt_q < 5'sd0 && diff < 5'sd0);
    sym_d  = blank_q ? tmds_token(c_q) :
             case_a  ? {~q8, q8, q8 ? qm : ~qm} :
             case_b  ? {1'b1, q8, ~qm} : {1'b0, q8, qm};
    cnt_d  = blank_q ? 5'sd0 :
             case_a  ? (q8 ? cnt_q + diff : cnt_q - diff) :
             case_b  ? cnt_q - diff + (q8 ? 5'sd2 : 5'sd0) :
                       cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qm_q      <= '0;
      blank_q   <= 1'b1;
      c_q       <= 2'b00;
      cnt_q     <= '0;
      sym_q     <= TMDS_CTRL_00;
      blank_o_q <= 1'b1;
    end else if (ena) begin
      qm_q      <= {!use_xnor, chain(data, use_xnor)};
      blank_q   <= blank;
      c_q       <= c;
      cnt_q     <= cnt_d;
      sym_q     <= sym_d;
      blank_o_q <= blank_q;
    end
  end
  assign sym     = C_PIPE_OUT ? sym_q : sym_d;
  assign blank_o = C_PIPE_OUT ? blank_o_q : blank_q;
endmodule

// File: rtl/vga_tmds_encoder.sv
// vga_tmds_encoder: three-lane DVI TMDS encoder fed by the vga timing generator.
module vga_tmds_encoder
  import tmds_pkg::*;
#(
  parameter bit C_PIPE_OUT = 1'b1
) (
  input logic               clk_pixel,
  input logic               rst,
  vga_tmds_encoder_if.slave bus
);
  // sync levels ride on blue as {c1,c0}; green and red carry token 00 in blanking
  tmds_channel_encoder #(.C_PIPE_OUT(C_PIPE_OUT)) u_b (
    .clk(clk_pixel), .rst(rst), .ena(bus.clk_pixel_ena), .data(bus.vga_b),
    .c({bus.vga_vsync, bus.vga_hsync}), .blank(bus.vga_blank),
    .sym(bus.tmds_b), .blank_o(bus.tmds_blank)
  );
  tmds_channel_encoder #(.C_PIPE_OUT(C_PIPE_OUT)) u_g (
    .clk(clk_pixel), .rst(rst), .ena(bus.clk_pixel_ena), .data(bus.vga_g),
    .c(2'b00), .blank(bus.vga_blank), .sym(bus.tmds_g), .blank_o()
  );
  tmds_channel_encoder #(.C_PIPE_OUT(C_PIPE_OUT)) u_r (
    .clk(clk_pixel), .rst(rst), .ena(bus.clk_pixel_ena), .data(bus.vga_r),
    .c(2'b00), .blank(bus.vga_blank), .sym(bus.tmds_r), .blank_o()
  );
endmodule

// File: tb/tb_vga_tmds_encoder.sv
// tb_vga_tmds_encoder: randomized and directed checks against a behavioural TMDS model.
module tb_vga_tmds_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  vga_tmds_encoder_if bus ();
  vga_tmds_encoder #(.C_PIPE_OUT(1'b1)) dut (.clk_pixel(clk), .rst(rst), .bus(bus));
  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  typedef struct {
    logic [9:0] r, g, b;
    logic       blk;
    logic [7:0] dr, dg, db;
  } ent_t;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   run = 1'b0;
  int   mc [3];
  ent_t p1, ex;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask
  function automatic ent_t rst_ent();
    ent_t e;
    e.r = 10'h354; e.g = 10'h354; e.b = 10'h354; e.blk = 1'b1;
    e.dr = 8'h00; e.dg = 8'h00; e.db = 8'h00;
    return e;
  endfunction
  function automatic logic [9:0] enc(input logic [7:0] d, input logic [1:0] c, input logic blk, input int ch);
    int n1d, n1, n0;
    logic xn, q8;
    logic [7:0] qm;
    if (blk) begin
      mc[ch] = 0;
      return TOK[c];
    end
    n1d = $countones(d);
    xn = n1d > 4 || (n1d == 4 && d[0] == 1'b0);
    q8 = !xn;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (mc[ch] == 0 || n1 == n0) begin
      mc[ch] += q8 ? n1 - n0 : n0 - n1;
      return {~q8, q8, q8 ? qm : ~qm};
    end
    if ((mc[ch] > 0 && n1 > n0) || (mc[ch] < 0 && n0 > n1)) begin
      mc[ch] += 2 * int'(q8) + n0 - n1;
      return {1'b1, q8, ~qm};
    end
    mc[ch] += n1 - n0 - 2 * int'(!q8);
    return {1'b0, q8, qm};
  endfunction
  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction
  // symbol for an input is formed when it is accepted; it shows two enabled edges later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc = '{0, 0, 0};
      p1 = rst_ent();
      ex = rst_ent();
    end else if (bus.clk_pixel_ena) begin
      ex = p1;
      p1.r = enc(bus.vga_r, 2'b00, bus.vga_blank, 0);
      p1.g = enc(bus.vga_g, 2'b00, bus.vga_blank, 1);
      p1.b = enc(bus.vga_b, {bus.vga_vsync, bus.vga_hsync}, bus.vga_blank, 2);
      p1.blk = bus.vga_blank;
      p1.dr = bus.vga_r; p1.dg = bus.vga_g; p1.db = bus.vga_b;
    end
  end
  always @(negedge clk) begin
    if (run && rst) begin
      chk("tmds_r", int'(bus.tmds_r), int'(ex.r));
      chk("tmds_g", int'(bus.tmds_g), int'(ex.g));
      chk("tmds_b", int'(bus.tmds_b), int'(ex.b));
      chk("tmds_blank", int'(bus.tmds_blank), int'(ex.blk));
      if (!ex.blk) begin
        chk("decode_r", int'(dec(bus.tmds_r)), int'(ex.dr));
        chk("decode_g", int'(dec(bus.tmds_g)), int'(ex.dg));
        chk("decode_b", int'(dec(bus.tmds_b)), int'(ex.db));
      end
      chk("disp_bound_r", int'($signed(dut.u_r.cnt_q) >= -10 && $signed(dut.u_r.cnt_q) <= 10), 1);
      chk("disp_bound_g", int'($signed(dut.u_g.cnt_q) >= -10 && $signed(dut.u_g.cnt_q) <= 10), 1);
      chk("disp_bound_b", int'($signed(dut.u_b.cnt_q) >= -10 && $signed(dut.u_b.cnt_q) <= 10), 1);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] r, g, b, input logic hs, vs, bl, en);
    bus.vga_r = r; bus.vga_g = g; bus.vga_b = b;
    bus.vga_hsync = hs; bus.vga_vsync = vs; bus.vga_blank = bl;
    bus.clk_pixel_ena = en;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_r"}, int'(bus.tmds_r), 'h354);
    chk({tag, "_g"}, int'(bus.tmds_g), 'h354);
    chk({tag, "_b"}, int'(bus.tmds_b), 'h354);
    chk({tag, "_blank"}, int'(bus.tmds_blank), 1);
    chk({tag, "_cnt_r"}, int'($signed(dut.u_r.cnt_q)), 0);
  endtask
  task automatic chk_r(input int sym, input int cnt);
    chk("zeros_tmds_r", int'(bus.tmds_r), sym);
    chk("zeros_cnt_r", int'($signed(dut.u_r.cnt_q)), cnt);
  endtask
  initial begin
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    run = 1'b1;
    repeat (2) step();
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); step(); chk_r('h100, -8);
    step(); chk_r('h3FF, 2);
    step(); chk_r('h100, -6);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step();
    drive(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); step();
    chk("ones_tmds_g", int'(bus.tmds_g), 'h200);
    chk("ones_cnt_g", int'($signed(dut.u_g.cnt_q)), -8);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(8'h5A, 8'hA5, 8'h3C, k[0], k[1], 1'b1, 1'b1);
      step();
      if (k >= 1) begin
        chk("token_tmds_b", int'(bus.tmds_b), int'(TOK[k-1]));
        chk("token_tmds_r", int'(bus.tmds_r), 'h354);
        chk("token_tmds_g", int'(bus.tmds_g), 'h354);
      end
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step();
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); step(); chk_r('h100, -8);
    bus.clk_pixel_ena = 1'b0;
    step(); chk_r('h100, -8);
    step(); chk_r('h100, -8);
    bus.clk_pixel_ena = 1'b1;
    step(); chk_r('h3FF, 2);
    step(); chk_r('h100, -6);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 80; x++) begin
        drive(8'(x[5] ? 8'hFF : x * 4), 8'(x[4] ? 8'hFF : y * 32), 8'(x[3] ? 8'hFF : x + y),
              x >= 68 && x < 72, y == 9, x >= 64 || y >= 8, 1'b1);
        step();
      end
    for (int i = 0; i < 3000; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0);
      step();
      if (i == 1500) begin
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (3) begin
          step();
          chk_reset_vals("midrst_hold");
        end
        rst = 1'b1;
      end
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
